// File: rtl/cprv_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// fetch_entry_t carries a {pc, instr} pair from imem to decode. Its pc field
// is FETCH_PC_W bits wide, so PC_WIDTH of the fetch unit may not exceed it.
package cprv_fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FETCH_PC_W  = 32;

  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  // Read/write pointer width: index bits plus one wrap bit. Never returns
  // less than 2, so the index slice [PTR_W-2:0] is always legal.
  function automatic int fetch_ptr_w(input int depth);
    return (depth < 2) ? 2 : $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cprv_fetch_fifo.sv
// Synchronous FIFO with a single-cycle flush, power-of-2 DEPTH.
// Latency: a push is visible at o_pop_dat / o_empty on the following cycle.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_flush       empties the FIFO at the next edge (wins over push/pop)
//   i_push/_dat   write request and data
//   i_pop         consume the head entry (ignored when empty)
//   o_pop_dat     head entry, valid whenever o_empty=0
//   o_empty       no entries held
//   o_count       number of entries held (0..DEPTH)
module cprv_fetch_fifo
  import cprv_fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t,
  parameter int  PTR_W = fetch_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  T                 i_push_dat,
  input  logic             i_pop,
  output T                 o_pop_dat,
  output logic             o_empty,
  output logic [PTR_W-1:0] o_count
);

  localparam int IDX_W = PTR_W - 1;

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  // Equal pointers mean empty; equal index with differing wrap bit means full.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_pop_dat = r_mem[r_rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: nothing is read until the pointers say it was written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/cprv_fetch_unit.sv
// Instruction-fetch front end: owns the PC, requests imem words, buffers {pc, instr} for decode.
// Latency: request handshake in cycle N, imem data in N+1, valid_dec in N+2 at the earliest.
// Backpressure: requests are issued only while a buffer slot is guaranteed for every reply, so ready_if stays 1.
//
// Optional feature macro: CPRV_FETCH_PERF_EN adds perf_fetch_cnt, perf_flush_cnt
// and perf_stall_cnt outputs. Without it the core behaviour is identical.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   valid_imem/ready_imem       address request channel, instr_addr_imem = pc
//   valid_if/ready_if           imem read-data channel carrying instr_data_imem
//   valid_dec/ready_dec         decode channel carrying instr_dec / pc_dec
//   redirect_valid/redirect_pc  one-cycle flush and jump to redirect_pc with bits [1:0] cleared
//   perf_*                      wrapping event counters (CPRV_FETCH_PERF_EN only)
module cprv_fetch_unit
  import cprv_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH        = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = '0,
  parameter int                  FIFO_DEPTH      = 4,
  parameter int                  MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                valid_imem,
  input  logic                ready_imem,
  output logic [PC_WIDTH-1:0] instr_addr_imem,
  input  logic                valid_if,
  output logic                ready_if,
  input  logic [31:0]         instr_data_imem,
  output logic                valid_dec,
  input  logic                ready_dec,
  output logic [31:0]         instr_dec,
  output logic [PC_WIDTH-1:0] pc_dec,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc
`ifdef CPRV_FETCH_PERF_EN
  ,
  output logic [63:0]         perf_fetch_cnt,
  output logic [31:0]         perf_flush_cnt,
  output logic [63:0]         perf_stall_cnt
`endif
);

  localparam int BUF_PW = fetch_ptr_w(FIFO_DEPTH);
  localparam int TAG_PW = fetch_ptr_w(MAX_OUTSTANDING);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  logic [PC_WIDTH-1:0] r_pc;
  logic [OUT_W-1:0]    r_outstanding;
  logic [OUT_W-1:0]    r_discard;
  logic [OUT_W-1:0]    w_out_next;
  logic                w_req_fire;
  logic                w_keep;
  logic                w_pop;
  logic                w_buf_empty;
  logic [BUF_PW-1:0]   w_buf_count;
  logic                w_tag_empty;
  logic [TAG_PW-1:0]   w_tag_count;
  logic [PC_WIDTH-1:0] w_tag_pc;
  fetch_entry_t        w_push_ent;
  fetch_entry_t        w_head_ent;

  // Every reply has a reserved buffer slot, so replies are never refused.
  assign ready_if = 1'b1;

  // Credit rule: in-flight requests plus buffered entries never exceed the
  // buffer depth. Replies that will be discarded still hold their credit,
  // which is conservative but keeps the rule a simple sum.
  assign valid_imem = !rst && !redirect_valid &&
                      (int'(r_outstanding) < MAX_OUTSTANDING) &&
                      (int'(w_tag_count) < MAX_OUTSTANDING) &&
                      ((int'(r_outstanding) + int'(w_buf_count)) < FIFO_DEPTH);
  assign instr_addr_imem = r_pc;

  assign w_req_fire = valid_imem && ready_imem;
  assign w_out_next = r_outstanding + OUT_W'(w_req_fire) - OUT_W'(valid_if);

  // A reply is kept only if it belongs to the current fetch stream: no stale
  // replies left to drop, and not arriving in a redirect cycle.
  assign w_keep = valid_if && (r_discard == '0) && !redirect_valid && !w_tag_empty;
  assign w_pop  = valid_dec && ready_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        r_pc      <= redirect_pc & ~PC_WIDTH'(3);
        // Everything still in flight after this cycle belongs to the old stream.
        r_discard <= w_out_next;
      end else begin
        if (w_req_fire) r_pc <= r_pc + PC_WIDTH'(INSTR_BYTES);
        if (valid_if && (r_discard != '0)) r_discard <= r_discard - OUT_W'(1);
      end
    end
  end

  // Addresses of issued requests, in order; the head tags the next kept reply.
  cprv_fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (logic [PC_WIDTH-1:0])
  ) u_tag_q (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redirect_valid),
    .i_push     (w_req_fire),
    .i_push_dat (r_pc),
    .i_pop      (w_keep),
    .o_pop_dat  (w_tag_pc),
    .o_empty    (w_tag_empty),
    .o_count    (w_tag_count)
  );

  always_comb begin
    w_push_ent       = '0;
    w_push_ent.pc    = FETCH_PC_W'(w_tag_pc);
    w_push_ent.instr = instr_data_imem;
  end

  cprv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_instr_buf (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redirect_valid),
    .i_push     (w_keep),
    .i_push_dat (w_push_ent),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head_ent),
    .o_empty    (w_buf_empty),
    .o_count    (w_buf_count)
  );

  assign valid_dec = !w_buf_empty;
  assign instr_dec = w_head_ent.instr;
  assign pc_dec    = PC_WIDTH'(w_head_ent.pc);

`ifdef CPRV_FETCH_PERF_EN
  logic [63:0] r_perf_fetch;
  logic [31:0] r_perf_flush;
  logic [63:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_pop)                       r_perf_fetch <= r_perf_fetch + 64'd1;
      if (redirect_valid)              r_perf_flush <= r_perf_flush + 32'd1;
      if (!valid_dec && !redirect_valid) r_perf_stall <= r_perf_stall + 64'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_flush_cnt = r_perf_flush;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_cprv_fetch_unit.sv
// Self-checking bench for cprv_fetch_unit: directed scenarios followed by random traffic.
// A behavioural imem answers requests in order with random latency; kept replies are
// queued as expected decode entries and a separate monitor compares every delivery.
module tb_cprv_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam int          MAXO   = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_imem;
  logic        ready_imem;
  logic [31:0] instr_addr_imem;
  logic        valid_if;
  logic        ready_if;
  logic [31:0] instr_data_imem;
  logic        valid_dec;
  logic        ready_dec;
  logic [31:0] instr_dec;
  logic [31:0] pc_dec;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef CPRV_FETCH_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
  logic [63:0] perf_stall_cnt;
  logic [63:0] m_fetch, m_stall;
  logic [31:0] m_flush;
`endif

  always #5 clk = ~clk;

  cprv_fetch_unit #(
    .PC_WIDTH(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .valid_imem(valid_imem), .ready_imem(ready_imem), .instr_addr_imem(instr_addr_imem),
    .valid_if(valid_if), .ready_if(ready_if), .instr_data_imem(instr_data_imem),
    .valid_dec(valid_dec), .ready_dec(ready_dec), .instr_dec(instr_dec), .pc_dec(pc_dec),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef CPRV_FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int epoch; int due; } imem_t;

  exp_t        exp_q[$];   // expected decode stream (mirrors buffer occupancy)
  imem_t       imem_q[$];  // requests accepted by the behavioural imem
  logic [31:0] pop_log[$];
  logic [31:0] hs_log[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int epoch = 0;
  int m_out = 0;
  int hs_count = 0;
  int first_hs_cycle = -1;
  int first_dec_cycle = -1;
  logic [31:0] exp_addr = RST_PC;
  bit mon_pop = 1'b0;

  int p_rdy_imem = 100;
  int p_rdy_dec  = 100;
  int lat_min    = 1;
  int lat_max    = 1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cycle, act, exp);
    end
  endtask

  // Monitor: compares each decode handshake with the head of the expected stream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      mon_pop = 1'b0;
      check("valid_dec", valid_dec, exp_q.size() != 0);
      if (valid_dec && ready_dec) begin
        mon_pop = 1'b1;
        pop_log.push_back(pc_dec);
        if (first_dec_cycle < 0) first_dec_cycle = cycle;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_dec cycle=%0d actual_pc=0x%0h expected=none", cycle, pc_dec);
        end else begin
          e = exp_q.pop_front();
          check("pc_dec", pc_dec, e.pc);
          check("instr_dec", instr_dec, e.instr);
        end
      end
    end
  end

  // One clock cycle: drive inputs at negedge, check and advance the model at negedge+2.
  task automatic step(input bit do_rst, input bit do_redir, input logic [31:0] rpc);
    bit    rsp, hs, exp_v;
    int    occ;
    imem_t r;
    @(negedge clk);
    cycle++;
    rst            = do_rst;
    redirect_valid = do_redir;
    redirect_pc    = rpc;
    ready_imem     = ($urandom_range(99) < p_rdy_imem);
    ready_dec      = !do_rst && ($urandom_range(99) < p_rdy_dec);
    rsp            = !do_rst && (imem_q.size() != 0) && (imem_q[0].due <= cycle);
    valid_if       = rsp;
    instr_data_imem = rsp ? instr_of(imem_q[0].addr) : $urandom();
    #2;
    occ   = exp_q.size() + (mon_pop ? 1 : 0);
    exp_v = !do_rst && !do_redir && (m_out < MAXO) && ((m_out + occ) < DEPTH);
    check("valid_imem", valid_imem, exp_v);
    check("ready_if", ready_if, 1'b1);
    if (valid_imem) check("instr_addr", instr_addr_imem, exp_addr);
`ifdef CPRV_FETCH_PERF_EN
    check("perf_fetch", perf_fetch_cnt, m_fetch);
    check("perf_flush", perf_flush_cnt, m_flush);
    check("perf_stall", perf_stall_cnt, m_stall);
`endif
    hs = valid_imem && ready_imem;
    if (do_rst) begin
      m_out = 0;
      epoch++;
      exp_q.delete();
      imem_q.delete();
      exp_addr = RST_PC;
`ifdef CPRV_FETCH_PERF_EN
      m_fetch = '0; m_flush = '0; m_stall = '0;
`endif
    end else begin
`ifdef CPRV_FETCH_PERF_EN
      if (occ > 0 && ready_dec) m_fetch++;
      if (do_redir) m_flush++;
      if (occ == 0 && !do_redir) m_stall++;
`endif
      if (rsp) begin
        r = imem_q.pop_front();
        m_out--;
        if (!do_redir && r.epoch == epoch) exp_q.push_back('{pc: r.addr, instr: instr_of(r.addr)});
      end
      if (hs) begin
        imem_q.push_back('{addr: exp_addr, epoch: epoch,
                           due: cycle + int'($urandom_range(lat_max, lat_min))});
        hs_log.push_back(exp_addr);
        m_out++;
        hs_count++;
        if (first_hs_cycle < 0) first_hs_cycle = cycle;
        exp_addr = exp_addr + 32'd4;
      end
      if (do_redir) begin
        epoch++;
        exp_q.delete();
        exp_addr = rpc & ~32'h3;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
  endtask

  task automatic check_log(input string name, input int idx, input logic [31:0] exp, input bit use_pop);
    logic [31:0] v;
    v = 32'hxxxx_xxxx;
    if (use_pop && pop_log.size() > idx) v = pop_log[idx];
    if (!use_pop && hs_log.size() > idx) v = hs_log[idx];
    check(name, {32'h0, v}, {32'h0, exp});
  endtask

  initial begin
    rst = 1'b1; ready_imem = 1'b0; valid_if = 1'b0; instr_data_imem = '0;
    ready_dec = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
`ifdef CPRV_FETCH_PERF_EN
    m_fetch = '0; m_flush = '0; m_stall = '0;
`endif

    // Streaming: one request per cycle, first decode two cycles after first request.
    do_reset();
    check("reset_valid_dec", valid_dec, 1'b0);
    check("reset_valid_imem", valid_imem, 1'b0);
    first_hs_cycle = -1; first_dec_cycle = -1; hs_count = 0; pop_log.delete();
    run(20);
    check("stream_hs_count", hs_count, 20);
    check("first_dec_latency", 64'(first_dec_cycle - first_hs_cycle), 64'd2);
    check_log("first_pc_dec", 0, RST_PC, 1'b1);

    // Decode stalled: exactly DEPTH requests, then release in order.
    do_reset();
    p_rdy_dec = 0; hs_count = 0;
    run(10);
    check("stall_hs_count", hs_count, DEPTH);
    check("stall_valid_imem", valid_imem, 1'b0);
    pop_log.delete(); p_rdy_dec = 100;
    run(8);
    for (int i = 0; i < 4; i++) check_log("stall_release_pc", i, 32'(i * 4), 1'b1);

    // Two requests in flight, redirect to a misaligned target.
    do_reset();
    lat_min = 4; lat_max = 4;
    step(1'b0, 1'b1, 32'h10);
    run(3);
    hs_log.delete(); pop_log.delete(); lat_min = 1; lat_max = 1;
    step(1'b0, 1'b1, 32'h203);
    run(12);
    check_log("redir_first_addr", 0, 32'h200, 1'b0);
    check_log("redir_first_pc_dec", 0, 32'h200, 1'b1);

    // Redirect in the same cycle as the only outstanding reply.
    do_reset();
    lat_min = 2; lat_max = 2;
    step(1'b0, 1'b0, 32'h0);
    p_rdy_imem = 0;
    step(1'b0, 1'b0, 32'h0);
    hs_log.delete(); pop_log.delete();
    step(1'b0, 1'b1, 32'h40);
    p_rdy_imem = 100; lat_min = 1; lat_max = 1;
    run(8);
    check_log("coincide_first_addr", 0, 32'h40, 1'b0);
    check_log("coincide_first_pc_dec", 0, 32'h40, 1'b1);

    // PC wrap at the top of the address space.
    hs_log.delete();
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    run(6);
    check_log("wrap_addr0", 0, 32'hFFFF_FFFC, 1'b0);
    check_log("wrap_addr1", 1, 32'h0000_0000, 1'b0);

    // Reset (together with a redirect) while requests are in flight and the buffer is filling.
    p_rdy_dec = 0; lat_min = 3; lat_max = 3;
    run(8);
    step(1'b1, 1'b1, 32'h500);
    step(1'b0, 1'b0, 32'h0);
    check("rst_mid_valid_dec", valid_dec, 1'b0);
    check("rst_mid_valid_imem", valid_imem, 1'b1);
    check("rst_mid_addr", instr_addr_imem, RST_PC);
`ifdef CPRV_FETCH_PERF_EN
    check("rst_perf_fetch", perf_fetch_cnt, 64'd0);
    check("rst_perf_flush", perf_flush_cnt, 64'd0);
    check("rst_perf_stall", perf_stall_cnt, 64'd0);
`endif

    // Random traffic with backpressure, variable latency, redirects and resets.
    lat_min = 1; lat_max = 4;
    for (int blk = 0; blk < 15; blk++) begin
      p_rdy_imem = 30 + int'($urandom_range(70));
      p_rdy_dec  = 20 + int'($urandom_range(80));
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(999) < 3, $urandom_range(99) < 3, $urandom());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cprv_fetch_unit.md
Name: cprv_fetch_unit

Overview:
- Instruction-fetch front end between the CPU decode stage and the instruction memory (cprv_ram_1p_w instance).
- Owns the PC and issues word addresses to imem over a valid/ready request channel.
- Accepts imem read data on a valid/ready response channel and buffers {pc, instr} pairs in a small FIFO for decode.
- Supports pipelined outstanding requests and branch/jump redirect with discard of stale in-flight responses.

Parameters:
- PC_WIDTH, 32, width of PC and imem address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, minimum 2.
- MAX_OUTSTANDING, 2, maximum imem requests in flight; must be ≤ FIFO_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_imem  out  1  address request valid.
- ready_imem  in  1  imem accepts address.
- instr_addr_imem  out  PC_WIDTH  fetch address.
- valid_if  in  1  imem read data valid.
- ready_if  out  1  fetch unit accepts read data.
- instr_data_imem  in  32  instruction word.
- valid_dec  out  1  instruction available to decode.
- ready_dec  in  1  decode consumes instruction.
- instr_dec  out  32  instruction.
- pc_dec  out  PC_WIDTH  PC of instr_dec.
- redirect_valid  in  1  flush and redirect, single-cycle pulse.
- redirect_pc  in  PC_WIDTH  new PC; bits [1:0] ignored and forced to 0.

Behaviour:
- Reset (clk rising edge, rst=1):
  - pc=RESET_PC, outstanding=0, discard=0, FIFO empty.
  - valid_imem=0, valid_dec=0, ready_if=1.
  - rst overrides a redirect in the same cycle.
- Request issue:
  - valid_imem=1 when !redirect_valid, outstanding<MAX_OUTSTANDING, and outstanding+fifo_count<FIFO_DEPTH. This credit rule guarantees every response has a FIFO slot.
  - instr_addr_imem=pc, held stable while valid_imem=1 and ready_imem=0.
  - On handshake: pc+=4 (wraps modulo 2^PC_WIDTH), outstanding+=1.
  - Back-to-back requests are allowed; one request per cycle maximum.
- Response: ready_if is tied to 1 and is never deasserted.
  - On valid_if: outstanding-=1.
  - If discard>0: drop the response and decrement discard.
  - Otherwise push {pc_tag, instr_data_imem}, where pc_tag comes from an internal tag queue of issued addresses (depth MAX_OUTSTANDING, in order).
- Simultaneous request and response: outstanding is unchanged.
- Output: valid_dec = FIFO not empty.
  - instr_dec and pc_dec show the FIFO head.
  - Pop on valid_dec & ready_dec.
  - Push and pop in the same cycle is legal when full or empty (pass-through latency ≥1 cycle; no combinational path from valid_if to valid_dec).
- Minimum latency: request handshake in cycle N, imem data in N+1, valid_dec in N+2.
- Redirect (redirect_valid=1):
  - FIFO cleared and tag queue cleared; pc<=redirect_pc & ~3.
  - valid_imem forced 0 that cycle.
  - discard<=outstanding_next, i.e. outstanding minus any response arriving that cycle; that response is dropped.
  - From the next cycle, fetch resumes at redirect_pc.
  - A redirect while discard>0 recomputes discard the same way.
  - A redirect during a pending (unaccepted) request withdraws it; imem tolerates valid drop.
  - A pop in the redirect cycle completes as a normal consumption.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits with wrap bit; full/empty from the pointer compare.

Optional Feature:
- Macro CPRV_FETCH_PERF_EN.
- Defined: adds output ports
  - perf_fetch_cnt (64): instructions delivered to decode.
  - perf_flush_cnt (32): redirects.
  - perf_stall_cnt (64): cycles with valid_dec=0 and no redirect.
  - All counters clear on rst and wrap silently.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package cprv_fetch_pkg:
  - typedef fetch_entry_t {pc, instr}.
  - constant INSTR_BYTES=4.
  - function clog2-safe pointer width.
- One sub-module, cprv_fetch_fifo: parameterized sync FIFO with flush input, storing fetch_entry_t. Used for both the instruction buffer and the tag queue.

Test Plan:
- Reset then ready_imem=1, imem 1-cycle latency, ready_dec=1 → addresses 0x0, 0x4, 0x8, … one per cycle; first valid_dec two cycles after first request, pc_dec=0x0.
- ready_dec=0 for 10 cycles → exactly FIFO_DEPTH=4 requests issued, then valid_imem=0. Release → pc_dec 0x0, 0x4, 0x8, 0xC in order, no loss.
- Two requests in flight (0x10, 0x14), redirect_pc=0x203 → both responses dropped; next request addr 0x200; first pc_dec=0x200.
- Redirect in the same cycle as a response arrives, outstanding=1 → response dropped, discard=0, no stale entry in the FIFO.
- pc=0xFFFF_FFFC with PC_WIDTH=32 → next address 0x0000_0000.
- rst asserted with outstanding=2 and FIFO full → the next cycle has valid_dec=0, valid_imem request at RESET_PC; with CPRV_FETCH_PERF_EN defined, all counters read 0.
